// File: rtl/audio_dac_i2s_tx.sv
// I2S transmitter for a stereo audio DAC: divides the 384 fs master clock to a 64 fs BCLK and
// serialises one frame per 64 slots. Define AUDIO_DAC_TX_HOLD_LAST_EN to repeat the last pair on underrun.
module audio_dac_i2s_tx #(
  parameter int DATA_W = 24
) (
  input  logic              clk,
  input  logic              reset_n,
  input  logic              pll_locked,
  input  logic [DATA_W-1:0] sample_left,
  input  logic [DATA_W-1:0] sample_right,
  input  logic              sample_valid,
  output logic              sample_ready,
  output logic              aud_bclk,
  output logic              aud_daclrck,
  output logic              aud_dacdat,
  output logic              underrun
);

  logic [1:0]        sync_q;
  logic              locked_s;
  logic [2:0]        d_q, d_d;
  logic [5:0]        b_q, b_d;
  logic              hold_valid_q, hold_valid_d;
  logic [DATA_W-1:0] hold_l_q, hold_l_d;
  logic [DATA_W-1:0] hold_r_q, hold_r_d;
  logic [63:0]       frame_q, frame_d;
  logic [63:0]       under_frame;
  logic              bclk_q, bclk_d;
  logic              lrck_q, lrck_d;
  logic              dat_q, dat_d;
  logic              underrun_q, underrun_d;
  logic              wrap, frame_load, xfer;

  // Each channel is left-justified in a 32-bit half of the frame word.
  function automatic logic [63:0] pack_frame(input logic [DATA_W-1:0] l,
                                             input logic [DATA_W-1:0] r);
    logic [31:0] lw;
    logic [31:0] rw;
    lw = '0;
    rw = '0;
    lw[31 -: DATA_W] = l;
    rw[31 -: DATA_W] = r;
    return {lw, rw};
  endfunction

  assign locked_s     = sync_q[1];
  assign sample_ready = locked_s & ~hold_valid_q;
  assign xfer         = sample_valid & sample_ready;
  assign wrap         = locked_s & (d_q == 3'd5);
  assign frame_load   = wrap & (b_q == 6'd63);

`ifdef AUDIO_DAC_TX_HOLD_LAST_EN
  logic [DATA_W-1:0] last_l_q, last_r_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      last_l_q <= '0;
      last_r_q <= '0;
    end else if (xfer) begin
      last_l_q <= sample_left;
      last_r_q <= sample_right;
    end
  end

  assign under_frame = pack_frame(last_l_q, last_r_q);
`else
  assign under_frame = '0;
`endif

  always_comb begin
    d_d          = d_q;
    b_d          = b_q;
    hold_valid_d = hold_valid_q;
    hold_l_d     = hold_l_q;
    hold_r_d     = hold_r_q;
    frame_d      = frame_q;
    bclk_d       = bclk_q;
    lrck_d       = lrck_q;
    dat_d        = dat_q;
    underrun_d   = 1'b0;
    if (!locked_s) begin
      d_d          = '0;
      b_d          = '0;
      hold_valid_d = 1'b0;
      frame_d      = '0;
      bclk_d       = 1'b0;
      lrck_d       = 1'b0;
      dat_d        = 1'b0;
    end else begin
      d_d    = wrap ? 3'd0 : d_q + 3'd1;
      b_d    = wrap ? b_q + 6'd1 : b_q;
      bclk_d = (d_d >= 3'd3);
      // Slot b+1 carries F[64-(b+1)]; at b=63 this picks F[0] of the outgoing frame.
      if (wrap) begin
        lrck_d = b_d[5];
        dat_d  = frame_q[6'd63 - b_q];
      end
      if (xfer) begin
        hold_valid_d = 1'b1;
        hold_l_d     = sample_left;
        hold_r_d     = sample_right;
      end
      // A pair accepted on the load cycle itself waits for the following frame.
      if (frame_load) begin
        underrun_d   = ~hold_valid_q;
        frame_d      = hold_valid_q ? pack_frame(hold_l_q, hold_r_q) : under_frame;
        hold_valid_d = xfer;
      end
    end
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      sync_q       <= '0;
      d_q          <= '0;
      b_q          <= '0;
      hold_valid_q <= 1'b0;
      hold_l_q     <= '0;
      hold_r_q     <= '0;
      frame_q      <= '0;
      bclk_q       <= 1'b0;
      lrck_q       <= 1'b0;
      dat_q        <= 1'b0;
      underrun_q   <= 1'b0;
    end else begin
      sync_q       <= {sync_q[0], pll_locked};
      d_q          <= d_d;
      b_q          <= b_d;
      hold_valid_q <= hold_valid_d;
      hold_l_q     <= hold_l_d;
      hold_r_q     <= hold_r_d;
      frame_q      <= frame_d;
      bclk_q       <= bclk_d;
      lrck_q       <= lrck_d;
      dat_q        <= dat_d;
      underrun_q   <= underrun_d;
    end
  end

  assign aud_bclk    = bclk_q;
  assign aud_daclrck = lrck_q;
  assign aud_dacdat  = dat_q;
  assign underrun    = underrun_q;

endmodule

// File: tb/tb_audio_dac_i2s_tx.sv
// Bench for audio_dac_i2s_tx: a frame-level model (absolute cycle count since lock) checked every
// cycle, plus directed scenarios with literal expectations on captured serial frames.
module tb_audio_dac_i2s_tx;
  localparam int DW = 24;
`ifdef AUDIO_DAC_TX_HOLD_LAST_EN
  localparam bit HOLD = 1'b1;
`else
  localparam bit HOLD = 1'b0;
`endif

  logic          clk;
  logic          reset_n;
  logic          pll_locked;
  logic [DW-1:0] sample_left, sample_right;
  logic          sample_valid;
  logic          sample_ready, aud_bclk, aud_daclrck, aud_dacdat, underrun;

  audio_dac_i2s_tx #(.DATA_W(DW)) dut (
    .clk          (clk),
    .reset_n      (reset_n),
    .pll_locked   (pll_locked),
    .sample_left  (sample_left),
    .sample_right (sample_right),
    .sample_valid (sample_valid),
    .sample_ready (sample_ready),
    .aud_bclk     (aud_bclk),
    .aud_daclrck  (aud_daclrck),
    .aud_dacdat   (aud_dacdat),
    .underrun     (underrun)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;
  int ucount = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s actual=%0h required=%0h at %0t", name, act, exp, $time);
    end
  endtask

  function automatic logic [63:0] frm(input logic [DW-1:0] l, input logic [DW-1:0] r);
    return {l, {(32-DW){1'b0}}, r, {(32-DW){1'b0}}};
  endfunction

  // Model: slot = (cycles since lock / 6) mod 64, frame index = cycles / 384.
  logic          m_sy1, m_ls, m_hv, m_und, m_bclk, m_lrck, m_dat, m_xfer;
  int            m_cnt, m_s;
  logic [DW-1:0] m_hl, m_hr, m_ll, m_lr;
  logic [63:0]   m_cur, m_prev;

  always @(posedge clk) begin
    if (!reset_n) begin
      m_sy1 = 0; m_ls = 0; m_hv = 0; m_und = 0; m_cnt = 0;
      m_hl = '0; m_hr = '0; m_ll = '0; m_lr = '0; m_cur = '0; m_prev = '0;
      m_bclk = 0; m_lrck = 0; m_dat = 0;
    end else begin
      m_xfer = sample_valid && m_ls && !m_hv;
      m_und  = 0;
      if (m_ls) begin
        m_cnt++;
        if (m_cnt % 384 == 0) begin
          m_und  = !m_hv;
          m_prev = m_cur;
          if (m_hv)      m_cur = frm(m_hl, m_hr);
          else if (HOLD) m_cur = frm(m_ll, m_lr);
          else           m_cur = '0;
          m_hv = 0;
        end
        if (m_xfer) begin
          m_hv = 1; m_hl = sample_left; m_hr = sample_right;
          m_ll = sample_left; m_lr = sample_right;
        end
        m_s    = (m_cnt / 6) % 64;
        m_bclk = (m_cnt % 6) >= 3;
        m_lrck = m_s >= 32;
        m_dat  = (m_s == 0) ? m_prev[0] : m_cur[64 - m_s];
      end else begin
        m_cnt = 0; m_hv = 0; m_cur = '0; m_prev = '0;
        m_bclk = 0; m_lrck = 0; m_dat = 0;
      end
      m_ls  = m_sy1;
      m_sy1 = pll_locked;
    end
    #1;
    chk("bclk", aud_bclk, m_bclk);
    chk("lrck", aud_daclrck, m_lrck);
    chk("dacdat", aud_dacdat, m_dat);
    chk("underrun", underrun, m_und);
    chk("ready", sample_ready, m_ls && !m_hv);
  end

  always @(negedge clk) if (underrun) ucount++;

  function automatic logic sig(input int sel);
    return (sel == 0) ? aud_bclk : aud_daclrck;
  endfunction

  // Waits (on negedges) for a rising or falling edge of bclk (sel 0) or lrck (sel 1).
  task automatic wait_edge(input int sel, input logic rise, output int n);
    logic prev, cur;
    bit   done;
    n = 0; done = 0; prev = sig(sel);
    while (!done && n < 1000) begin
      @(negedge clk);
      n++;
      cur = sig(sel);
      if (prev == !rise && cur == rise) done = 1;
      prev = cur;
    end
    if (!done) begin
      checks++; errors++;
      $display("FAIL edge_timeout sel=%0d actual=none required=edge", sel);
    end
  endtask

  task automatic capture(output logic [63:0] bits);
    int n;
    bits = '0;
    wait_edge(1, 1'b0, n);
    for (int k = 0; k < 64; k++) begin
      wait_edge(0, 1'b1, n);
      bits[k] = aud_dacdat;
    end
  endtask

  task automatic check_frame(input logic [63:0] bits, input logic [DW-1:0] l,
                             input logic [DW-1:0] r, input string name);
    logic [DW-1:0] lv, rv;
    logic [6:0]    pad;
    for (int k = 0; k < DW; k++) begin
      lv[DW-1-k] = bits[1+k];
      rv[DW-1-k] = bits[33+k];
    end
    pad = bits[31:25];
    chk({name, "_left"}, lv, l);
    chk({name, "_pad"}, pad, 0);
    chk({name, "_right"}, rv, r);
  endtask

  task automatic push(input logic [DW-1:0] l, input logic [DW-1:0] r);
    int n;
    bit done;
    n = 0; done = 0;
    sample_left = l; sample_right = r; sample_valid = 1'b1;
    while (!done && n < 1000) begin
      if (sample_ready) done = 1;
      @(negedge clk);
      n++;
    end
    sample_valid = 1'b0;
    if (!done) begin
      checks++; errors++;
      $display("FAIL push_timeout actual=no_ready required=ready");
    end
  endtask

  task automatic bringup(input string name);
    int n;
    repeat (3) @(negedge clk);
    chk({name, "_ready_by_3"}, sample_ready, 1);
    wait_edge(0, 1'b1, n);
    wait_edge(0, 1'b1, n);
    chk({name, "_bclk_period"}, n, 6);
    wait_edge(0, 1'b0, n);
    chk({name, "_bclk_high"}, n, 3);
    wait_edge(1, 1'b1, n);
    wait_edge(1, 1'b1, n);
    chk({name, "_lrck_period"}, n, 384);
  endtask

  initial begin
    logic [63:0] f;
    int          n, u0, bad;
    reset_n = 0; pll_locked = 0; sample_valid = 0;
    sample_left = '0; sample_right = '0;
    repeat (3) @(negedge clk);
    chk("reset_outs", {sample_ready, aud_bclk, aud_daclrck, aud_dacdat, underrun}, 5'b0);
    pll_locked = 1;
    #3 reset_n = 1;
    bringup("boot");

    push(24'hA5A5A5, 24'h5A5A5A);
    capture(f);
    check_frame(f, 24'hA5A5A5, 24'h5A5A5A, "pushed");

    u0 = ucount;
    capture(f);
    check_frame(f, HOLD ? 24'hA5A5A5 : 24'h0, HOLD ? 24'h5A5A5A : 24'h0, "under1");
    capture(f);
    check_frame(f, HOLD ? 24'hA5A5A5 : 24'h0, HOLD ? 24'h5A5A5A : 24'h0, "under2");
    chk("underrun_count", ucount - u0, 2);

    // Holding register full: valid must be ignored until the next frame load.
    wait_edge(1, 1'b1, n);
    push(24'h123456, 24'h654321);
    sample_left = 24'hC0FFEE; sample_right = 24'h0BADF0; sample_valid = 1;
    bad = 0;
    repeat (50) begin
      @(negedge clk);
      if (sample_ready !== 1'b0) bad++;
    end
    chk("ready_while_full", bad, 0);
    wait_edge(1, 1'b0, n);
    chk("ready_after_load", sample_ready, 1);
    @(negedge clk);
    sample_valid = 0;
    capture(f);
    check_frame(f, 24'hC0FFEE, 24'h0BADF0, "second_pair");

    // Lock loss at slot 40 with a pair waiting in the holding register.
    push(24'h111111, 24'h222222);
    wait_edge(1, 1'b1, n);
    repeat (48) @(negedge clk);
    u0 = ucount;
    pll_locked = 0;
    repeat (3) @(negedge clk);
    chk("unlock_outs", {sample_ready, aud_bclk, aud_daclrck, aud_dacdat, underrun}, 5'b0);
    repeat (20) @(negedge clk);
    pll_locked = 1;
    repeat (3) @(negedge clk);
    push(24'h333333, 24'h444444);
    bad = 0;
    repeat (150) begin
      @(negedge clk);
      if (aud_daclrck !== 1'b0 || aud_dacdat !== 1'b0) bad++;
    end
    chk("relock_zero_left", bad, 0);
    repeat (300) @(negedge clk);
    chk("relock_no_underrun", ucount - u0, 0);

    // Asynchronous reset mid-frame.
    @(negedge clk);
    #2 reset_n = 0;
    #1 chk("async_reset_outs", {sample_ready, aud_bclk, aud_daclrck, aud_dacdat, underrun}, 5'b0);
    repeat (4) @(negedge clk);
    #3 reset_n = 1;
    bringup("rerun");

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
